uart_tx_serializer: RTL and testbench

//  Serial UART transmitter stage that sits directly downstream of UART_FIFO_TX.

---
 rtl/uart_tx_serializer.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
// Purpose : UART transmit serializer; shifts one start/data/[parity]/stop frame LSB first on tx.
// Latency : tx drops to the start bit one clk after tx_start is accepted; tx_done pulses one clk
//           after the final stop-bit tick.
// Backpressure: tx_start is only honoured in IDLE (tx_busy=0); requests while busy are dropped.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset; aborts any frame, line returns to idle-high
//   s_tick   - 16x oversample enable from the baud generator, one clk wide
//   tx_start - request from the TX FIFO; d_in is valid
//   d_in     - byte to transmit, bits [DBIT-1:0] used
//   tx_done  - one-clk pulse when the stop bit completes (FIFO pop strobe)
//   tx_busy  - high whenever a frame is in progress
//   tx       - serial line output, idles high
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
// All three outputs come straight from flops; their next values are decoded from next-state.

module uart_tx_serializer #(
    parameter int DBIT    = 8,   // data bits per frame, 5..8
    parameter int SB_TICK = 16   // stop-bit length in s_tick units: 16, 24 or 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] d_in,
    output logic       tx_done,
    output logic       tx_busy,
    output logic       tx
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
`endif

    localparam logic [4:0] BIT_LAST_TICK  = 5'd15;
    localparam logic [4:0] STOP_LAST_TICK = 5'(SB_TICK - 1);
    localparam logic [2:0] LAST_BIT       = 3'(DBIT - 1);

    state_t            state_q, state_d;
    logic [4:0]        s_q, s_d;          // oversample tick counter within a bit
    logic [2:0]        n_q, n_d;          // data bit index
    logic [DBIT-1:0]   shreg_q, shreg_d;  // outgoing data, bit 0 is on the line
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;      // even parity of the accepted byte
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // s_tick is deliberately ignored here; bit timing restarts at accept.
                if (tx_start) begin
                    shreg_d = d_in[DBIT-1:0];
                    s_d     = '0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^d_in[DBIT-1:0];
`endif
                end
            end

            ST_START: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST_TICK) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST_TICK) begin
                        s_d     = '0;
                        shreg_d = shreg_q >> 1;
                        n_d     = n_q + 3'd1;
                        if (n_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST_TICK) begin
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`endif

            ST_STOP: begin
                // A tx_start arriving on the final tick is not seen: we are still in STOP.
                if (s_tick) begin
                    if (s_q == STOP_LAST_TICK) begin
                        s_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered output decode: values are computed from the next state so
    // the flops present the correct line level in the very cycle the state
    // register changes.
    // ------------------------------------------------------------------
    always_comb begin
        tx_d   = 1'b1;
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
        busy_d = (state_d != ST_IDLE);

        unique case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for uart_tx_serializer against a tick-counting frame model.
// Latency : model expects start bit one clk after accept and tx_done after the last stop tick.
// Backpressure: model drops tx_start while a frame is in flight.

module tb_uart_tx_serializer;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Start + data + optional parity bits, each 16 ticks; then the stop bit.
    localparam int NBITS = 1 + DBIT + PAR;
    localparam int TOTAL = 16 * NBITS + SB_TICK;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       tx_done;
    logic       tx_busy;
    logic       tx;

    uart_tx_serializer #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tick   (s_tick),
        .tx_start (tx_start),
        .d_in     (d_in),
        .tx_done  (tx_done),
        .tx_busy  (tx_busy),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // s_tick generator: one pulse every tick_period clocks.
    // ------------------------------------------------------------------
    int tick_period = 1;
    int tick_ph = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick_ph = tick_ph + 1;
            if (tick_ph >= tick_period) tick_ph = 0;
            s_tick = (tick_ph == 0);
        end
    end

    // ------------------------------------------------------------------
    // Reference model: a frame is a list of line levels, each held for 16
    // ticks, followed by SB_TICK ticks of stop. Only ticks that arrive after
    // the accept edge count.
    // ------------------------------------------------------------------
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    int               m_ticks = 0;
    logic [NBITS-1:0] m_bits = '0;

    function automatic logic [NBITS-1:0] make_frame(input logic [7:0] d);
        logic [NBITS-1:0] f;
        logic p;
        f = '0;
        p = 1'b0;
        for (int i = 0; i < DBIT; i++) begin
            f[1+i] = d[i];
            p = p ^ d[i];
        end
        if (PAR == 1) f[NBITS-1] = p;
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int t;
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_ticks <= 0;
            m_bits  <= '0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (tx_start) begin
                m_busy  <= 1'b1;
                m_ticks <= 0;
                m_bits  <= make_frame(d_in);
            end
        end else begin
            t = m_ticks + (s_tick ? 1 : 0);
            m_ticks <= t;
            if (t == TOTAL) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    function automatic logic exp_tx();
        int idx;
        if (!m_busy) return 1'b1;
        idx = m_ticks / 16;
        if (idx < NBITS) return m_bits[idx];
        return 1'b1;
    endfunction

    // Cycle-by-cycle comparison and tx_done pulse counting, away from the active edge.
    int done_cnt = 0;
    always @(negedge clk) begin
        check_val("tx", {31'b0, tx}, {31'b0, exp_tx()});
        check_val("tx_busy", {31'b0, tx_busy}, {31'b0, m_busy});
        check_val("tx_done", {31'b0, tx_done}, {31'b0, m_done});
        if (tx_done) done_cnt = done_cnt + 1;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_pulse(input logic [7:0] d);
        d_in = d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    // Returns number of busy cycles observed; an expired budget is a failure.
    task automatic wait_idle(input int budget, output int busy_cycles);
        busy_cycles = 0;
        while (tx_busy && busy_cycles < budget) begin
            busy_cycles++;
            @(posedge clk);
            #1;
        end
        if (tx_busy) check_val("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_ticks(input int target, input int budget);
        int c;
        c = 0;
        while (m_ticks < target && c < budget) begin
            c++;
            @(posedge clk);
            #1;
        end
        if (m_ticks < target) check_val("wait_ticks_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!tx_done && c < budget) begin
            c++;
            @(posedge clk);
            #1;
        end
        if (!tx_done) check_val("wait_done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int len;
        int d0;
        int mode;
        int gap;
        logic [7:0] b;

        // 1: reset and idle hold
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("rst_tx", {31'b0, tx}, 32'd1);
        check_val("rst_busy", {31'b0, tx_busy}, 32'd0);
        check_val("rst_done", {31'b0, tx_done}, 32'd0);
        repeat (50) @(posedge clk);
        #1;
        check_val("idle_tx", {31'b0, tx}, 32'd1);
        check_val("idle_busy", {31'b0, tx_busy}, 32'd0);

        // 2: single frame 0x32, full-rate tick
        d0 = done_cnt;
        send_pulse(8'h32);
        wait_idle(TOTAL + 50, len);
        check_val("single_busy_len", len, TOTAL);
        repeat (3) @(posedge clk);
        #1;
        check_val("single_done_cnt", done_cnt - d0, 32'd1);

        // 3: back-to-back with tx_start held
        d0 = done_cnt;
        d_in = 8'hA5;
        tx_start = 1'b1;
        wait_done(TOTAL + 50);
        d_in = 8'h5A;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        check_val("b2b_second_busy", {31'b0, tx_busy}, 32'd1);
        wait_idle(TOTAL + 50, len);
        repeat (5) @(posedge clk);
        #1;
        check_val("b2b_done_cnt", done_cnt - d0, 32'd2);

        // 4: tx_start while busy is dropped
        d0 = done_cnt;
        send_pulse(8'h00);
        wait_ticks(16 * 3 + 5, 500);
        send_pulse(8'hFF);
        wait_idle(TOTAL + 50, len);
        repeat (40) @(posedge clk);
        #1;
        check_val("ignore_busy_after", {31'b0, tx_busy}, 32'd0);
        check_val("ignore_done_cnt", done_cnt - d0, 32'd1);

        // 5: reset in the middle of data bit 3
        d0 = done_cnt;
        send_pulse(8'hC3);
        wait_ticks(16 * 4 + 8, 500);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_tx", {31'b0, tx}, 32'd1);
        check_val("async_rst_busy", {31'b0, tx_busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("abort_no_done", done_cnt - d0, 32'd0);
        send_pulse(8'h96);
        wait_idle(TOTAL + 50, len);
        check_val("post_rst_len", len, TOTAL);

        // 6: slow tick (every 4 clk), d_in=0x07 (parity 1 when enabled)
        tick_period = 4;
        send_pulse(8'h07);
        wait_idle(4 * TOTAL + 50, len);
        check_val("slow_len_window",
                  {31'b0, (len >= 4 * TOTAL - 3) && (len <= 4 * TOTAL)}, 32'd1);
        tick_period = 1;
        repeat (4) @(posedge clk);
        #1;

        // Randomised frames: rate, data, start style and spurious requests vary.
        for (int k = 0; k < 24; k++) begin
            tick_period = $urandom_range(1, 3);
            b = 8'($urandom_range(0, 255));
            mode = $urandom_range(0, 2);
            d0 = done_cnt;
            if (mode == 2) begin
                d_in = b;
                tx_start = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                tx_start = 1'b0;
                d_in = 8'($urandom_range(0, 255));
            end else begin
                send_pulse(b);
                d_in = 8'($urandom_range(0, 255));
            end
            if (mode == 1) begin
                repeat ($urandom_range(10, 100)) @(posedge clk);
                #1;
                send_pulse(8'($urandom_range(0, 255)));
            end
            wait_idle(4 * TOTAL + 50, len);
            gap = $urandom_range(2, 15);
            repeat (gap) @(posedge clk);
            #1;
            check_val("rand_done_cnt", done_cnt - d0, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
